// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - two-requester round-robin command arbiter for a shared up/down/load counter
//
// Purpose:
//   Accepts INC/DEC/LD/NOP commands from requesters A and B, picks one per
//   four-cycle transaction (IDLE -> GRANT -> EXEC -> DONE), latches its
//   operands and drives one command strobe to the external counter register.
//
// Optional feature:
//   CNT_ARB_SAT_EN - when defined, INC at all-ones and DEC at zero are
//   suppressed in EXEC and reported on sat instead of strobing.
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-low reset
//   req_a/op_a/din_a  requester A request, opcode (00 NOP 01 INC 10 DEC 11 LD), load value
//   req_b/op_b/din_b  requester B, same meaning
//   count          current counter register value
//   inc/dec/ld     command strobes to the counter register (EXEC only)
//   in             load value to the counter register (latched din in EXEC, else 0)
//   gnt_a/gnt_b    one-cycle grant pulse (GRANT state)
//   done_a/done_b  one-cycle completion pulse (DONE state)
//   busy           high in every state except IDLE
//   sat            one-cycle pulse when a command is suppressed by saturation

module counter_arbiter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [1:0]       op_a,
  input  logic [WIDTH-1:0] din_a,
  input  logic             req_b,
  input  logic [1:0]       op_b,
  input  logic [WIDTH-1:0] din_b,
  input  logic [WIDTH-1:0] count,
  output logic             inc,
  output logic             dec,
  output logic             ld,
  output logic [WIDTH-1:0] in,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic             busy,
  output logic             sat
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_INC = 2'b01;
  localparam logic [1:0] OP_DEC = 2'b10;
  localparam logic [1:0] OP_LD  = 2'b11;

`ifdef CNT_ARB_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic [1:0]       r_state;
  logic             r_ptr_b;   // 1: B holds priority when both request
  logic             r_win_b;   // 1: current transaction belongs to B
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_din;

  logic             w_win_b;
  logic             w_exec;
  logic             w_sat_hit;
  logic             w_sup;

  // A lone requester always wins; on contention the pointer decides.
  assign w_win_b = req_b & (~req_a | r_ptr_b);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr_b <= 1'b0;
      r_win_b <= 1'b0;
      r_op    <= OP_NOP;
      r_din   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_a || req_b) begin
            r_state <= S_GRANT;
            r_win_b <= w_win_b;
            r_op    <= w_win_b ? op_b  : op_a;
            r_din   <= w_win_b ? din_b : din_a;
          end
        end
        S_GRANT: r_state <= S_EXEC;
        S_EXEC:  r_state <= S_DONE;
        S_DONE: begin
          r_state <= S_IDLE;
          r_ptr_b <= ~r_win_b;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_exec = (r_state == S_EXEC);

  // Saturation is evaluated against the live count during EXEC; it is only
  // acted on when the feature is built in.
  assign w_sat_hit = ((r_op == OP_INC) && (count == {WIDTH{1'b1}})) ||
                     ((r_op == OP_DEC) && (count == {WIDTH{1'b0}}));
  assign w_sup     = SAT_EN & w_exec & w_sat_hit;

  assign inc    = w_exec & (r_op == OP_INC) & ~w_sup;
  assign dec    = w_exec & (r_op == OP_DEC) & ~w_sup;
  assign ld     = w_exec & (r_op == OP_LD);
  assign in     = w_exec ? r_din : '0;
  assign sat    = w_sup;

  assign gnt_a  = (r_state == S_GRANT) & ~r_win_b;
  assign gnt_b  = (r_state == S_GRANT) &  r_win_b;
  assign done_a = (r_state == S_DONE)  & ~r_win_b;
  assign done_b = (r_state == S_DONE)  &  r_win_b;
  assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_counter_arbiter.sv
// tb/tb_counter_arbiter.sv - directed self-checking bench for counter_arbiter

module tb_counter_arbiter;

  localparam int WIDTH = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_a, req_b;
  logic [1:0]       op_a, op_b;
  logic [WIDTH-1:0] din_a, din_b, count;
  logic             inc, dec, ld;
  logic [WIDTH-1:0] in;
  logic             gnt_a, gnt_b, done_a, done_b, busy, sat;

  int vecs = 0;
  int errs = 0;

`ifdef CNT_ARB_SAT_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif

  counter_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .op_a(op_a), .din_a(din_a),
    .req_b(req_b), .op_b(op_b), .din_b(din_b),
    .count(count),
    .inc(inc), .dec(dec), .ld(ld), .in(in),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .busy(busy), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {14'd0, inc, dec, ld, in, gnt_a, gnt_b, done_a, done_b, busy, sat};
  endfunction

  initial begin
    rst = 1'b0; req_a = 0; req_b = 0; op_a = 0; op_b = 0;
    din_a = 0; din_b = 0; count = 0;
    step(); step();
    chk("reset_outputs", all_outs(), 0);

    // LD from A right after reset release
    rst = 1'b1; req_a = 1; op_a = 2'b11; din_a = 6'd42;
    step();
    chk("ld_gnt_a", gnt_a, 1); chk("ld_gnt_b", gnt_b, 0);
    chk("ld_busy_grant", busy, 1); chk("ld_in_grant", in, 0);
    step();
    chk("ld_strobe", ld, 1); chk("ld_in", in, 42);
    chk("ld_no_incdec", {inc, dec}, 0); chk("ld_busy_exec", busy, 1);
    step();
    chk("ld_done_a", done_a, 1); chk("ld_done_b", done_b, 0);
    chk("ld_off_in_done", {ld, in}, 0); chk("ld_busy_done", busy, 1);
    req_a = 0;
    step();
    chk("ld_idle_busy", busy, 0); chk("ld_idle_done", done_a, 0);

    // Round robin from a fresh pointer: A, B, A, B
    rst = 1'b0;
    step();
    rst = 1'b1; count = 6'd10;
    req_a = 1; op_a = 2'b01; req_b = 1; op_b = 2'b01;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_gnt_a", gnt_a, (k % 2 == 0) ? 1 : 0);
      chk("rr_gnt_b", gnt_b, (k % 2 == 1) ? 1 : 0);
      chk("rr_inc_grant", inc, 0);
      step();
      chk("rr_inc_exec", inc, 1);
      step();
      chk("rr_done", {done_a, done_b}, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("rr_inc_done", inc, 0);
      step();
      chk("rr_idle", {busy, inc}, 0);
    end
    req_a = 0; req_b = 0;

    // INC at all-ones from B
    count = 6'd63; req_b = 1; op_b = 2'b01;
    step();
    chk("sat_inc_gnt_b", gnt_b, 1);
    step();
    chk("sat_inc_strobe", inc, SAT ? 0 : 1);
    chk("sat_inc_flag", sat, SAT ? 1 : 0);
    step();
    chk("sat_inc_done_b", done_b, 1); chk("sat_inc_flag_done", sat, 0);
    req_b = 0;
    step();
    chk("sat_inc_idle", busy, 0);

    // DEC at zero from A, then a NOP from A
    count = 6'd0; req_a = 1; op_a = 2'b10;
    step();
    chk("sat_dec_gnt_a", gnt_a, 1);
    step();
    chk("sat_dec_strobe", dec, SAT ? 0 : 1);
    chk("sat_dec_flag", sat, SAT ? 1 : 0);
    step();
    chk("sat_dec_done_a", done_a, 1);
    op_a = 2'b00;
    step();
    chk("nop_idle_gap", busy, 0);
    step();
    chk("nop_gnt_a", gnt_a, 1);
    step();
    chk("nop_no_strobe", {inc, dec, ld, sat}, 0); chk("nop_busy", busy, 1);
    step();
    chk("nop_done_a", done_a, 1);
    req_a = 0;
    step();

    // Operands change and request drops after grant: latched command stands
    count = 6'd20; req_a = 1; op_a = 2'b01; din_a = 6'd5;
    step();
    chk("latch_gnt_a", gnt_a, 1);
    op_a = 2'b11; din_a = 6'd9; req_a = 0;
    step();
    chk("latch_inc", {inc, ld}, 2'b10); chk("latch_in", in, 5);
    step();
    chk("latch_done_a", done_a, 1);
    step();

    // Reset during EXEC of an A INC (pointer currently favours B)
    req_a = 1; op_a = 2'b01; din_a = 0;
    step();
    chk("abort_gnt_a", gnt_a, 1);
    step();
    chk("abort_inc", inc, 1);
    rst = 1'b0;
    step();
    chk("abort_outputs", all_outs(), 0);
    rst = 1'b1; req_b = 1; op_b = 2'b01;
    step();
    chk("post_reset_gnt", {gnt_a, gnt_b}, 2'b10);
    chk("post_reset_no_done", done_a, 0);
    step();
    chk("post_reset_inc", inc, 1);
    req_a = 0; req_b = 0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
